dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data_memory port between the core load/store path (port C) and a debug/DMA
//  requester (port D). Single-cycle transactions; burst-capped owner-keeps arbitration.
//  Misaligned accesses are blocked from memory and reported. Sits between core datapath and data_memory.
// PARAMETERS
//  AW         32  address width
//  DW         32  data width
//  MAX_BURST  4   max consecutive grants to one owner while the other is requesting (>=1)
// PORTS
//  clk      in   1   clock, rising edge
//  rst      in   1   synchronous reset, active-low
//  c_req    in   1   core request (held until c_gnt)
//  c_we     in   1   core 1=store, 0=load
//  c_addr   in   AW  core byte address
//  c_wdata  in   DW  core store data
//  c_fun3   in   3   core size/sign code (RV32 LB/LH/LW/LBU/LHU, SB/SH/SW)
//  c_gnt    out  1   core transaction accepted this cycle (combinational)
//  c_rvalid out  1   core load response valid, one cycle after granted load
//  c_rdata  out  DW  core load data (valid with c_rvalid)
//  c_err    out  1   core misaligned flag (with c_rvalid or cycle after granted store)
//  d_req    in   1   debug request
//  d_we     in   1   debug 1=store, 0=load
//  d_addr   in   AW  debug byte address
//  d_wdata  in   DW  debug store data
//  d_fun3   in   3   debug size/sign code
//  d_gnt    out  1   debug accepted this cycle (combinational)
//  d_rvalid out  1   debug load response valid
//  d_rdata  out  DW  debug load data
//  d_err    out  1   debug misaligned flag
//  mem_rd_en  out 1  data_memory read enable
//  mem_wd_en  out 1  data_memory write enable
//  mem_addr   out AW data_memory address (muxed from winner, 0 when idle)
//  mem_wdata  out DW data_memory write data
//  mem_fun3   out 3  data_memory fun3
//  mem_rdata  in  DW data_memory combinational read data
// BEHAVIOUR
//  FSM {IDLE, OWN_C, OWN_D} = owner of previous cycle; burst_cnt counts its consecutive grants.
//  Reset (rst==0 at edge): state=IDLE, last=C, burst_cnt=0, all rvalid/err/rdata regs=0.
//  Winner: only one req -> it. Both req: IDLE -> C if last==C else D... i.e. last owner;
//    OWN_x with burst_cnt<MAX_BURST -> x; burst_cnt==MAX_BURST -> other. No req -> none.
//  Grant x: state->OWN_x; burst_cnt=1 on owner change, else +1 saturating at MAX_BURST; last=x.
//  No grant: state->IDLE, burst_cnt->0, last kept. At most one gnt per cycle.
//  Misaligned: fun3[1:0]==01 & addr[0], or fun3[1:0]==10 & addr[1:0]!=0. Still granted,
//    mem_rd_en/mem_wd_en held 0; next cycle x_err=1, x_rdata=0, x_rvalid=1 only if load.
//  Aligned load granted: mem_rd_en=1 same cycle; mem_rdata registered; x_rvalid=1, x_rdata valid next cycle.
//  Aligned store granted: mem_wd_en=1 same cycle; no rvalid. rvalid/err are 1-cycle pulses.
//  Requests with fun3 unchanged pass through to mem_fun3; 11 sizes treated as aligned word.
//  Reset mid-operation: pending responses dropped, no mem enables during reset cycle.
// TESTING
//  C only, LW addr 0x10, mem_rdata 0xDEADBEEF -> c_gnt same cycle, c_rvalid=1 c_rdata=0xDEADBEEF next.
//  C and D held 10 cycles, MAX_BURST=4, from reset -> grants C,C,C,C,D,D,D,D,C,C.
//  C SH addr 0x13 -> c_gnt=1, mem_wd_en=0, c_err=1 next cycle, c_rvalid=0.
//  D LB addr 0x21 -> mem_rd_en=1, d_rvalid=1 d_err=0 next cycle; c stays idle.
//  Both req, req drops 1 cycle -> IDLE, burst resets; last owner regains priority on return.
//  rst=0 in cycle after granted load -> no rvalid, all outputs 0, state IDLE.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: core (C), debug (D) and data_memory signal bundle for dmem_arbiter
//  slave  : arbiter side (takes requests and mem_rdata, drives grants, responses and mem_*)
//  master : requester/memory side
interface dmem_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [2:0]    c_fun3;
  logic          c_gnt;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;
  logic          c_err;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [2:0]    d_fun3;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          d_err;
  logic          mem_rd_en;
  logic          mem_wd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_fun3;
  logic [DW-1:0] mem_rdata;
  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_fun3,
    input  d_req, d_we, d_addr, d_wdata, d_fun3,
    input  mem_rdata,
    output c_gnt, c_rvalid, c_rdata, c_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_rd_en, mem_wd_en, mem_addr, mem_wdata, mem_fun3
  );
  modport master (
    output c_req, c_we, c_addr, c_wdata, c_fun3,
    output d_req, d_we, d_addr, d_wdata, d_fun3,
    output mem_rdata,
    input  c_gnt, c_rvalid, c_rdata, c_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_rd_en, mem_wd_en, mem_addr, mem_wdata, mem_fun3
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares data_memory between core (C) and debug/DMA (D) with burst-capped owner-keeps arbitration
//  clk : rising-edge clock
//  rst : synchronous reset, active-low
//  bus : dmem_arbiter_if slave (C/D request, grant, response ports and data_memory port)
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input logic            clk,
  input logic            rst,
  dmem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, OWN_C, OWN_D} state_t;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MAXB = BW'(MAX_BURST);
  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          c_rvalid_q, c_rvalid_d, c_err_q, c_err_d;
  logic          d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;
  logic          c_mis, d_mis, c_pri, c_win, d_win, gnt, same;
  logic          sel_we, sel_mis;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [2:0]    sel_fun3;
  function automatic logic misaligned(input logic [2:0] f, input logic [1:0] a);
    return (f[1:0] == 2'b01 && a[0]) || (f[1:0] == 2'b10 && a != 2'b00);
  endfunction
  always_comb begin
    c_mis      = misaligned(bus.c_fun3, bus.c_addr[1:0]);
    d_mis      = misaligned(bus.d_fun3, bus.d_addr[1:0]);
    // C wins a contested cycle: from idle if it was last owner, while it owns below the cap, or when D hit the cap
    c_pri      = state_q == IDLE ? !last_q : state_q == OWN_C ? burst_q < MAXB : burst_q == MAXB;
    c_win      = rst && bus.c_req && (!bus.d_req || c_pri);
    d_win      = rst && bus.d_req && !c_win;
    gnt        = c_win || d_win;
    sel_we     = c_win ? bus.c_we : bus.d_we;
    sel_mis    = c_win ? c_mis : d_mis;
    sel_addr   = c_win ? bus.c_addr : bus.d_addr;
    sel_wdata  = c_win ? bus.c_wdata : bus.d_wdata;
    sel_fun3   = c_win ? bus.c_fun3 : bus.d_fun3;
    same       = (c_win && state_q == OWN_C) || (d_win && state_q == OWN_D);
    state_d    = c_win ? OWN_C : d_win ? OWN_D : IDLE;
    last_d     = gnt ? d_win : last_q;
    burst_d    = !gnt ? '0 : !same ? BW'(1) : burst_q == MAXB ? burst_q : burst_q + 1'b1;
    c_rvalid_d = c_win && !bus.c_we;
    c_err_d    = c_win && c_mis;
    c_rdata_d  = (c_win && !bus.c_we && !c_mis) ? bus.mem_rdata : '0;
    d_rvalid_d = d_win && !bus.d_we;
    d_err_d    = d_win && d_mis;
    d_rdata_d  = (d_win && !bus.d_we && !d_mis) ? bus.mem_rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b0;
      burst_q    <= '0;
      c_rvalid_q <= 1'b0;
      c_err_q    <= 1'b0;
      c_rdata_q  <= '0;
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      burst_q    <= burst_d;
      c_rvalid_q <= c_rvalid_d;
      c_err_q    <= c_err_d;
      c_rdata_q  <= c_rdata_d;
      d_rvalid_q <= d_rvalid_d;
      d_err_q    <= d_err_d;
      d_rdata_q  <= d_rdata_d;
    end
  end
  // responses are masked while reset is held so a pending response never escapes
  assign bus.c_gnt     = c_win;
  assign bus.d_gnt     = d_win;
  assign bus.c_rvalid  = rst && c_rvalid_q;
  assign bus.c_err     = rst && c_err_q;
  assign bus.c_rdata   = rst ? c_rdata_q : '0;
  assign bus.d_rvalid  = rst && d_rvalid_q;
  assign bus.d_err     = rst && d_err_q;
  assign bus.d_rdata   = rst ? d_rdata_q : '0;
  assign bus.mem_rd_en = gnt && !sel_we && !sel_mis;
  assign bus.mem_wd_en = gnt && sel_we && !sel_mis;
  assign bus.mem_addr  = gnt ? sel_addr : '0;
  assign bus.mem_wdata = gnt ? sel_wdata : '0;
  assign bus.mem_fun3  = gnt ? sel_fun3 : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with directed per-cycle vectors
module tb_dmem_arbiter;
  localparam logic [2:0] LB = 3'b000, SH = 3'b001, LW = 3'b010, LHU = 3'b101;
  typedef struct packed {
    int          cyc;
    logic [1:0]  who;
    logic        rd;
    logic        wd;
    logic [31:0] addr;
    logic [2:0]  fun3;
    logic [31:0] wdata;
  } gnt_t;
  typedef struct packed {
    int          cyc;
    logic        port;
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;
  } resp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic done = 1'b0;
  logic checked = 1'b0;
  gnt_t  gq[$];
  resp_t rq[$];
  gnt_t  got_g, exp_g;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();
  dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic step(input logic r_n, input logic cr, input logic cwe, input logic [31:0] ca,
                      input logic [2:0] cf, input logic dr, input logic dwe, input logic [31:0] da,
                      input logic [2:0] df, input logic [31:0] rd, input int who, input logic mis,
                      input logic drop);
    logic        we;
    logic [31:0] a, wd;
    logic [2:0]  f;
    rst = r_n;
    bus.c_req = cr; bus.c_we = cwe; bus.c_addr = ca; bus.c_fun3 = cf; bus.c_wdata = ca ^ 32'hC0DE0000;
    bus.d_req = dr; bus.d_we = dwe; bus.d_addr = da; bus.d_fun3 = df; bus.d_wdata = da ^ 32'hD0D00000;
    bus.mem_rdata = rd;
    if (who != 0) begin
      we = who == 1 ? cwe : dwe;
      a  = who == 1 ? ca : da;
      f  = who == 1 ? cf : df;
      wd = who == 1 ? ca ^ 32'hC0DE0000 : da ^ 32'hD0D00000;
      gq.push_back('{cyc, who[1:0], !we && !mis, we && !mis, a, f, wd});
      if (!drop && (!we || mis)) rq.push_back('{cyc + 1, who == 2, !we, mis, mis ? 32'h0 : rd});
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    step(1, 0, 0, 0, LB, 0, 0, 0, LB, 0, 0, 0, 0);
  endtask
  task automatic both(input logic [31:0] ca, input logic [31:0] da, input logic [31:0] rd, input int who);
    step(1, 1, 0, ca, LW, 1, 0, da, LW, rd, who, 0, 0);
  endtask
  task automatic chk_resp(input logic p, input logic v, input logic e, input logic [31:0] d);
    resp_t g, x;
    g = '{cyc, p, v, e, d};
    n_cmp++;
    if (rq.size() == 0) begin
      n_fail++;
      $display("FAIL resp_unexpected cyc=%0d port=%0d rvalid=%b err=%b rdata=%h required none", cyc, p, v, e, d);
    end else begin
      x = rq.pop_front();
      if (g !== x) begin
        n_fail++;
        $display("FAIL resp cyc=%0d got port=%0d rvalid=%b err=%b rdata=%h required cyc=%0d port=%0d rvalid=%b err=%b rdata=%h",
                 cyc, p, v, e, d, x.cyc, x.port, x.rvalid, x.err, x.rdata);
      end
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if ({bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.d_rvalid, bus.c_err, bus.d_err, bus.mem_rd_en, bus.mem_wd_en} != 8'h0
          || bus.c_rdata != 0 || bus.d_rdata != 0 || bus.mem_addr != 0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d gnt=%b%b rvalid=%b%b err=%b%b en=%b%b addr=%h required all zero",
                 cyc, bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.d_rvalid, bus.c_err, bus.d_err,
                 bus.mem_rd_en, bus.mem_wd_en, bus.mem_addr);
      end
    end else begin
      if (bus.c_gnt || bus.d_gnt) begin
        n_cmp++;
        got_g = '{cyc, (bus.c_gnt && bus.d_gnt) ? 2'd3 : bus.c_gnt ? 2'd1 : 2'd2, bus.mem_rd_en, bus.mem_wd_en,
                  bus.mem_addr, bus.mem_fun3, bus.mem_wdata};
        if (gq.size() == 0) begin
          n_fail++;
          $display("FAIL grant_unexpected cyc=%0d who=%0d required none", cyc, got_g.who);
        end else begin
          exp_g = gq.pop_front();
          if (got_g !== exp_g) begin
            n_fail++;
            $display("FAIL grant cyc=%0d got who=%0d rd=%b wd=%b addr=%h fun3=%h wdata=%h required cyc=%0d who=%0d rd=%b wd=%b addr=%h fun3=%h wdata=%h",
                     cyc, got_g.who, got_g.rd, got_g.wd, got_g.addr, got_g.fun3, got_g.wdata,
                     exp_g.cyc, exp_g.who, exp_g.rd, exp_g.wd, exp_g.addr, exp_g.fun3, exp_g.wdata);
          end
        end
      end else begin
        n_cmp++;
        if (bus.mem_rd_en || bus.mem_wd_en || bus.mem_addr != 0) begin
          n_fail++;
          $display("FAIL idle_mem cyc=%0d rd=%b wd=%b addr=%h required 0 0 0", cyc, bus.mem_rd_en, bus.mem_wd_en, bus.mem_addr);
        end
      end
      if (bus.c_rvalid || bus.c_err) chk_resp(1'b0, bus.c_rvalid, bus.c_err, bus.c_rdata);
      if (bus.d_rvalid || bus.d_err) chk_resp(1'b1, bus.d_rvalid, bus.d_err, bus.d_rdata);
    end
    if (done && !checked) begin
      n_cmp++;
      if (gq.size() != 0 || rq.size() != 0) begin
        n_fail++;
        $display("FAIL leftover pending grants=%0d responses=%0d required 0 0", gq.size(), rq.size());
      end
      checked = 1'b1;
    end
  end
  initial begin
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0; bus.c_fun3 = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_fun3 = 0;
    bus.mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    step(1, 1, 0, 32'h10, LW, 0, 0, 0, LB, 32'hDEADBEEF, 1, 0, 0);
    idle();
    for (int i = 0; i < 10; i++) both(32'h100 + 4 * i, 32'h200 + 4 * i, 32'h1000 + i, (i >= 4 && i <= 7) ? 2 : 1);
    idle();
    step(1, 1, 1, 32'h13, SH, 0, 0, 0, LB, 32'h0, 1, 1, 0);
    idle();
    step(1, 0, 0, 0, LB, 1, 0, 32'h21, LB, 32'h55, 2, 0, 0);
    step(1, 0, 0, 0, LB, 1, 0, 32'h22, LW, 32'h77, 2, 1, 0);
    step(1, 1, 0, 32'h12, LHU, 0, 0, 0, LB, 32'h1234, 1, 0, 0);
    step(1, 1, 1, 32'h24, LW, 0, 0, 0, LB, 32'h0, 1, 0, 0);
    idle();
    step(1, 0, 0, 0, LB, 1, 0, 32'h30, LW, 32'h3030, 2, 0, 0);
    both(32'h140, 32'h240, 32'h2001, 2);
    both(32'h144, 32'h244, 32'h2002, 2);
    idle();
    for (int i = 0; i < 5; i++) both(32'h150 + 4 * i, 32'h250 + 4 * i, 32'h3000 + i, i == 4 ? 1 : 2);
    idle();
    step(1, 0, 0, 0, LB, 1, 0, 32'h40, LW, 32'hABCD, 2, 0, 1);
    step(0, 1, 0, 32'h44, LW, 1, 0, 32'h48, LW, 32'h0, 0, 0, 0);
    both(32'h60, 32'h64, 32'h6060, 1);
    idle();
    idle();
    done = 1'b1;
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
